// File: rtl/serial_addsub_unit.sv
// Chunk-serial add/subtract unit: CHUNK bits per clock, LSB chunk first,
// start/busy/done handshake, registered result and {N,C,V,Z} flags.
module serial_addsub_unit #(
  parameter int N     = 8,
  parameter int CHUNK = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  localparam int P  = N / CHUNK;
  localparam int CW = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [N-1:0]    x_r;
  logic [N-1:0]    y_r;
  logic [N-1:0]    acc_r;
  logic [1:0]      op_r;
  logic            carry_r;

  logic [CHUNK-1:0] x_chunk_s;
  logic [CHUNK-1:0] y_chunk_s;
  logic [CHUNK-1:0] sum_chunk_s;
  logic             cout_s;
  logic [N-1:0]     full_sum_s;
  logic             v_s;
  logic             c_flag_s;

  // Chunk adder; on the last chunk its MSBs are the operand/sum sign bits,
  // so V is read straight off the chunk (for subtract ~Y carries Y's sign inverted).
  always_comb begin
    x_chunk_s = x_r[CHUNK-1:0];
    if (op_r == 2'b00) begin
      y_chunk_s = y_r[CHUNK-1:0];
    end else begin
      y_chunk_s = ~y_r[CHUNK-1:0];
    end
    {cout_s, sum_chunk_s} = {1'b0, x_chunk_s} + {1'b0, y_chunk_s} + {{CHUNK{1'b0}}, carry_r};
    full_sum_s = (N'(sum_chunk_s) << (N - CHUNK)) | (acc_r >> CHUNK);
    v_s = (x_chunk_s[CHUNK-1] == y_chunk_s[CHUNK-1]) &&
          (sum_chunk_s[CHUNK-1] != x_chunk_s[CHUNK-1]);
    if (op_r == 2'b00) begin
      c_flag_s = cout_s;
    end else begin
      c_flag_s = ~cout_s;
    end
  end

  // Control FSM, operand/accumulator shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      x_r     <= {N{1'b0}};
      y_r     <= {N{1'b0}};
      acc_r   <= {N{1'b0}};
      op_r    <= 2'b00;
      carry_r <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= {N{1'b0}};
      flags   <= 4'b0000;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            if (op == 2'b10) begin
              x_r <= b;
              y_r <= a;
            end else begin
              x_r <= a;
              y_r <= b;
            end
            op_r    <= op;
            carry_r <= (op != 2'b00);
            acc_r   <= {N{1'b0}};
            cnt_r   <= {CW{1'b0}};
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          x_r     <= x_r >> CHUNK;
          y_r     <= y_r >> CHUNK;
          acc_r   <= full_sum_s;
          carry_r <= cout_s;
          if (cnt_r == CW'(P - 1)) begin
            cnt_r   <= {CW{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
            flags   <= {full_sum_s[N-1], c_flag_s, v_s, (full_sum_s == {N{1'b0}})};
            if (op_r != 2'b11) begin
              result <= full_sum_s;
            end else begin
              result <= result;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
            done  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Directed self-checking bench for serial_addsub_unit (N=8, CHUNK=2).
module tb_serial_addsub_unit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [3:0] flags;

  int errors;
  int checks;

  serial_addsub_unit #(.N(8), .CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one op, scramble inputs during RUN, wait (bounded) for done.
  task automatic run_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = ~o; a = ~x; b = ~y;
    lat = 0; bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 8'h00; b = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, result, flags} !== 14'h0000) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b result=%h flags=%b, want all zero",
               busy, done, result, flags);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sub();
    int lat, bcnt;
    run_op(2'b01, 8'h05, 8'h05, lat, bcnt);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL sub_latency: got %0d want 4", lat); end
    checks++;
    if (bcnt !== 4) begin errors++; $display("FAIL sub_busy_cycles: got %0d want 4", bcnt); end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== 8'h00 || flags !== 4'b0001) begin
      errors++;
      $display("FAIL sub_zero: got done=%b busy=%b result=%h flags=%b want 1 0 00 0001",
               done, busy, result, flags);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_pulse_width: got done=%b busy=%b want 0 0", done, busy);
    end
    run_op(2'b01, 8'h03, 8'h05, lat, bcnt);
    checks++;
    if (done !== 1'b1 || result !== 8'hFE || flags !== 4'b1100) begin
      errors++;
      $display("FAIL sub_borrow: got done=%b result=%h flags=%b want 1 fe 1100", done, result, flags);
    end
    run_op(2'b01, 8'h80, 8'h01, lat, bcnt);
    checks++;
    if (done !== 1'b1 || result !== 8'h7F || flags !== 4'b0010) begin
      errors++;
      $display("FAIL sub_overflow: got done=%b result=%h flags=%b want 1 7f 0010", done, result, flags);
    end
  endtask

  task automatic test_add();
    int lat, bcnt;
    run_op(2'b00, 8'hFF, 8'h01, lat, bcnt);
    checks++;
    if (done !== 1'b1 || result !== 8'h00 || flags !== 4'b0101) begin
      errors++;
      $display("FAIL add_carry: got done=%b result=%h flags=%b want 1 00 0101", done, result, flags);
    end
    run_op(2'b00, 8'h7F, 8'h01, lat, bcnt);
    checks++;
    if (done !== 1'b1 || result !== 8'h80 || flags !== 4'b1010) begin
      errors++;
      $display("FAIL add_overflow: got done=%b result=%h flags=%b want 1 80 1010", done, result, flags);
    end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d want 4", lat); end
  endtask

  task automatic test_revsub_compare();
    int lat, bcnt;
    run_op(2'b10, 8'h05, 8'h03, lat, bcnt);
    checks++;
    if (done !== 1'b1 || result !== 8'hFE || flags !== 4'b1100) begin
      errors++;
      $display("FAIL revsub: got done=%b result=%h flags=%b want 1 fe 1100", done, result, flags);
    end
    run_op(2'b00, 8'h01, 8'h01, lat, bcnt);
    checks++;
    if (result !== 8'h02 || flags !== 4'b0000) begin
      errors++; $display("FAIL add_small: got result=%h flags=%b want 02 0000", result, flags);
    end
    run_op(2'b11, 8'h10, 8'h20, lat, bcnt);
    checks++;
    if (done !== 1'b1 || result !== 8'h02 || flags !== 4'b1100) begin
      errors++;
      $display("FAIL compare: got done=%b result=%h flags=%b want 1 02 1100", done, result, flags);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 8'h11; b = 8'h22;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) pulses++;
      if (i == 4) begin
        checks++;
        if (done !== 1'b1 || result !== 8'h33) begin
          errors++; $display("FAIL b2b_first: got done=%b result=%h want 1 33", done, result);
        end
      end
      if (i == 5) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++; $display("FAIL b2b_no_gap: got busy=%b done=%b want 1 0", busy, done);
        end
      end
      if (i == 9) begin
        checks++;
        if (done !== 1'b1 || result !== 8'h45) begin
          errors++; $display("FAIL b2b_second: got done=%b result=%h want 1 45", done, result);
        end
      end
      a = 8'(8'h40 + i);
      b = 8'h01;
    end
    start = 1'b0;
    checks++;
    if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
  endtask

  task automatic test_reset_midrun();
    int lat, bcnt, pulses;
    pulses = 0;
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 8'hAA; b = 8'h11;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, flags} !== 14'h0000) begin
      errors++;
      $display("FAIL midrun_reset: got busy=%b done=%b result=%h flags=%b want all zero",
               busy, done, result, flags);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL aborted_done: got %0d pulses want 0", pulses); end
    run_op(2'b00, 8'h12, 8'h34, lat, bcnt);
    checks++;
    if (done !== 1'b1 || result !== 8'h46 || flags !== 4'b0000) begin
      errors++;
      $display("FAIL after_reset_add: got done=%b result=%h flags=%b want 1 46 0000", done, result, flags);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_sub();
    test_add();
    test_revsub_compare();
    test_back_to_back();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_addsub_unit.md
Name: serial_addsub_unit

Overview:
- Multi-cycle, chunk-serial add/subtract unit with a start/busy/done handshake.
- Processes CHUNK bits per clock, LSB chunk first, over an N-bit operand.
- Produces a registered result and a 4-bit status flag word.
- Successor to the combinational N-bit subtractor: adds add/sub/reverse-sub/compare modes, full NCVZ flags and a configurable area/latency trade-off.

Parameters:
- N, 8, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 2, bits processed per clock; P = N/CHUNK cycles per operation.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request operation; sampled only when not busy.
- op  input  2  00 add a+b; 01 sub a-b; 10 reverse sub b-a; 11 compare (a-b, flags only).
- a  input  N  operand A; sampled with start.
- b  input  N  operand B; sampled with start.
- busy  output  1  high while chunks are being processed.
- done  output  1  one-cycle pulse; result/flags updated in the same cycle.
- result  output  N  last computed value; held between operations.
- flags  output  4  {N, C, V, Z} = bit3 negative, bit2 carry/borrow, bit1 signed overflow, bit0 zero.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; chunk counter is 0.
  - busy=0, done=0, result=0, flags=4'b0000; internal shift registers are cleared.
  - Reset wins over any in-flight operation; no done pulse is produced for an aborted operation.
- States: IDLE, RUN, DONE.
  - IDLE/DONE, start=1 at edge k:
    - latch a and b; for op=10 swap them, so X=b, Y=a; otherwise X=a, Y=b.
    - latch op; carry_in = 0 for add, 1 for the subtract ops.
    - enter RUN; busy=1 from edge k.
  - RUN: each edge adds the next CHUNK of X and (Y for add, ~Y for subtract) plus the running carry, and shifts the sum chunk into the accumulator.
    - Counter counts 0..P-1.
    - The edge that processes chunk P-1 (edge k+P) enters DONE.
    - busy=0 and done=1 in the cycle after edge k+P.
    - For op!=11, result takes the full sum at edge k+P; for op=11, result is unchanged.
  - DONE: lasts one cycle.
    - Returns to IDLE at the next edge, unless start=1, in which case it enters RUN directly (back-to-back operation, no idle gap).
  - start while busy=1 is ignored and not queued; op, a and b changes during RUN have no effect.
- Latency: done is high exactly P+1 edges after the start-sampling edge, counting that edge as 1 (for N=8, CHUNK=2: start at edge k, done high in the cycle after edge k+4).
- Flags are computed from the full N-bit sum S and written at edge k+P for every op, including compare:
  - Z = (S == 0).
  - N = S[N-1].
  - C = final carry_out for add; C = ~final carry_out for subtract ops, i.e. 1 = borrow (X < Y unsigned).
  - V (add) = X and Y have the same sign and S's sign differs from it.
  - V (subtract) = X and Y have different signs and S[N-1] != X[N-1].
- result/flags never change outside the done cycle, except on reset.
- All arithmetic is modulo 2^N; no saturation.

Test Plan:
- N=8, CHUNK=2, op=01, a=0x05, b=0x05 -> done at edge k+4 with result=0x00, flags=4'b0001; busy high for exactly 4 cycles.
- op=01, a=0x03, b=0x05 -> result=0xFE, flags=4'b1100 (negative, borrow).
- op=00, a=0xFF, b=0x01 -> result=0x00, flags=4'b0101; then a=0x7F, b=0x01 -> result=0x80, flags=4'b1010 (overflow).
- op=10, a=0x05, b=0x03 -> result=0xFE, flags=4'b1100; then op=11, a=0x10, b=0x20 -> result stays 0xFE, flags=4'b1100.
- start held high for 10 cycles with changing a/b -> exactly one operation is accepted during RUN, with operands from edge k; start=1 in the done cycle launches a second operation with no idle cycle.
- Assert rst_n=0 mid-RUN after chunk 2 -> busy, done, result and flags go to 0 immediately, no done pulse; after release, op=00, a=0x12, b=0x34 -> result=0x46, flags=4'b0000.
